// File: rtl/mc_control_unit.sv
// Multicycle MIPS-style control unit: a Moore FSM that sequences the datapath
// through fetch, decode and per-instruction execute/writeback states.
// Optional feature: define MC_ADDI_EN to add the addi path (states 10/11);
// without it, addi is treated as an illegal opcode and halts the machine.
//
// state  | meaning
// -------+-----------------------------------------------
// FETCH  | read instruction, load IR, PC <= PC+4
// DECODE | precompute branch target, dispatch on opCode
// MEMADR | compute lw/sw effective address
// MEMRD  | read data memory
// MEMWB  | write loaded word to rt
// MEMWR  | write rt to data memory
// EXEC   | R-type ALU operation
// RWB    | write ALU result to rd
// BRANCH | beq compare, conditional PC update
// JUMP   | unconditional PC update
// ADDIEX | addi ALU operation (MC_ADDI_EN only)
// ADDIWB | write addi result to rt (MC_ADDI_EN only)
// HALT   | illegal opcode, absorbing until reset
module mc_control_unit #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      opCode,
  output logic            PCWriteCond,
  output logic            PCWrite,
  output logic            IorD,
  output logic            r_wbar,
  output logic            memToReg,
  output logic            IRWrite,
  output logic            aluSrcA,
  output logic            RegWrite,
  output logic            RegDst,
  output logic [1:0]      PCSrc,
  output logic [1:0]      aluop,
  output logic [1:0]      aluSrcB,
  output logic [ST_W-1:0] state,
  output logic            illegal
);

  typedef enum logic [ST_W-1:0] {
    FETCH  = 0,
    DECODE = 1,
    MEMADR = 2,
    MEMRD  = 3,
    MEMWB  = 4,
    MEMWR  = 5,
    EXEC   = 6,
    RWB    = 7,
    BRANCH = 8,
    JUMP   = 9,
`ifdef MC_ADDI_EN
    ADDIEX = 10,
    ADDIWB = 11,
`endif
    HALT   = 15
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       w_pcwc, w_pcw, w_iord, w_rwbar, w_m2r, w_irw, w_srca, w_regw, w_regdst;
  logic [1:0] w_pcsrc, w_aluop, w_srcb;

  // State register and sticky illegal flag; reset lands in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | (w_next == HALT);
    end
  end

  // Next-state and Moore output decode; opCode is only looked at in DECODE/MEMADR.
  always_comb begin
    w_next   = r_state;
    w_pcwc   = 1'b0;
    w_pcw    = 1'b0;
    w_iord   = 1'b0;
    w_rwbar  = 1'b1;
    w_m2r    = 1'b0;
    w_irw    = 1'b0;
    w_srca   = 1'b0;
    w_regw   = 1'b0;
    w_regdst = 1'b0;
    w_pcsrc  = 2'b00;
    w_aluop  = 2'b00;
    w_srcb   = 2'b00;
    case (r_state)
      FETCH: begin
        w_irw  = 1'b1;
        w_pcw  = 1'b1;
        w_srcb = 2'b01;
        w_next = DECODE;
      end
      DECODE: begin
        w_srcb = 2'b11;
        case (opCode)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RT:        w_next = EXEC;
          OP_BEQ:       w_next = BRANCH;
          OP_J:         w_next = JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      w_next = ADDIEX;
`endif
          default:      w_next = HALT;
        endcase
      end
      MEMADR: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        // IR cannot legally change here; anything but lw/sw means corruption.
        if (opCode == OP_LW)      w_next = MEMRD;
        else if (opCode == OP_SW) w_next = MEMWR;
        else                      w_next = HALT;
      end
      MEMRD: begin
        w_iord = 1'b1;
        w_next = MEMWB;
      end
      MEMWB: begin
        w_m2r  = 1'b1;
        w_regw = 1'b1;
        w_next = FETCH;
      end
      MEMWR: begin
        w_iord  = 1'b1;
        w_rwbar = 1'b0;
        w_next  = FETCH;
      end
      EXEC: begin
        w_srca  = 1'b1;
        w_aluop = 2'b10;
        w_next  = RWB;
      end
      RWB: begin
        w_regdst = 1'b1;
        w_regw   = 1'b1;
        w_next   = FETCH;
      end
      BRANCH: begin
        w_srca  = 1'b1;
        w_aluop = 2'b01;
        w_pcwc  = 1'b1;
        w_pcsrc = 2'b01;
        w_next  = FETCH;
      end
      JUMP: begin
        w_pcw   = 1'b1;
        w_pcsrc = 2'b10;
        w_next  = FETCH;
      end
`ifdef MC_ADDI_EN
      ADDIEX: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_next = ADDIWB;
      end
      ADDIWB: begin
        w_regw = 1'b1;
        w_next = FETCH;
      end
`endif
      HALT:    w_next = HALT;
      default: w_next = HALT;
    endcase
  end

  // Write strobes are forced safe while reset is held, independent of decode.
  assign PCWriteCond = w_pcwc & rst_n;
  assign PCWrite     = w_pcw  & rst_n;
  assign IRWrite     = w_irw  & rst_n;
  assign RegWrite    = w_regw & rst_n;
  assign r_wbar      = w_rwbar | ~rst_n;
  assign IorD        = w_iord;
  assign memToReg    = w_m2r;
  assign aluSrcA     = w_srca;
  assign RegDst      = w_regdst;
  assign PCSrc       = w_pcsrc;
  assign aluop       = w_aluop;
  assign aluSrcB     = w_srcb;
  assign state       = r_state;
  assign illegal     = r_illegal;

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 The block SHALL have parameter ST_W, default 4, giving the width of the state register and of the state output.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port opCode  input  6  instruction opcode from the datapath IR.
REQ-005 The block SHALL have outputs PCWriteCond, PCWrite, IorD, r_wbar, memToReg, IRWrite, aluSrcA, RegWrite, RegDst, each 1 bit, which are the datapath control strobes.
REQ-006 The block SHALL have outputs PCSrc, aluop, aluSrcB, each 2 bits, which are the datapath mux and ALU selects.
REQ-007 The block SHALL have outputs state (ST_W bits, current state) and illegal (1 bit, sticky illegal-opcode flag).

Function
REQ-008 The block SHALL be a Moore FSM: every output SHALL be decoded from the registered state only, with no opCode-to-output combinational path.
REQ-009 The block SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=15.
REQ-010 Outside the states listed below, every output SHALL take its default: strobes 0, selects 00, r_wbar=1.
REQ-011 In FETCH the block SHALL drive IorD=0, r_wbar=1, IRWrite=1, aluSrcA=0, aluSrcB=01, aluop=00, PCSrc=00, PCWrite=1, and SHALL go to DECODE.
REQ-012 In DECODE the block SHALL drive aluSrcA=0, aluSrcB=11, aluop=00, and SHALL branch on opCode: 100011 or 101011 go to MEMADR, 000000 goes to EXEC, 000100 goes to BRANCH, 000010 goes to JUMP, 001000 goes to ADDIEX (subject to REQ-025), and any other opcode goes to HALT.
REQ-013 In MEMADR the block SHALL drive aluSrcA=1, aluSrcB=10, aluop=00, and SHALL go to MEMRD when the opcode is lw or to MEMWR when it is sw.
REQ-014 In MEMRD the block SHALL drive IorD=1, r_wbar=1, and SHALL go to MEMWB.
REQ-015 In MEMWB the block SHALL drive RegDst=0, memToReg=1, RegWrite=1, and SHALL go to FETCH.
REQ-016 In MEMWR the block SHALL drive IorD=1, r_wbar=0, and SHALL go to FETCH.
REQ-017 In EXEC the block SHALL drive aluSrcA=1, aluSrcB=00, aluop=10, and SHALL go to RWB.
REQ-018 In RWB the block SHALL drive RegDst=1, memToReg=0, RegWrite=1, and SHALL go to FETCH.
REQ-019 In BRANCH the block SHALL drive aluSrcA=1, aluSrcB=00, aluop=01, PCWriteCond=1, PCSrc=01, and SHALL go to FETCH.
REQ-020 In JUMP the block SHALL drive PCWrite=1, PCSrc=10, and SHALL go to FETCH.
REQ-021 In ADDIEX the block SHALL drive aluSrcA=1, aluSrcB=10, aluop=00, and SHALL go to ADDIWB; in ADDIWB it SHALL drive RegDst=0, memToReg=0, RegWrite=1, and SHALL go to FETCH.
REQ-022 HALT SHALL be absorbing: all outputs at default and illegal=1 until reset; any unencoded state value SHALL also go to HALT on the next edge.
REQ-023 Instruction latencies in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-024 opCode SHALL be sampled only in DECODE and MEMADR, because IR is stable after FETCH; opCode changes in any other state SHALL have no effect.

Configuration
REQ-025 With macro MC_ADDI_EN defined, opcode 001000 SHALL follow the DECODE, ADDIEX, ADDIWB, FETCH path; without it, states 10 and 11 SHALL be absent and opcode 001000 SHALL go to HALT with illegal=1.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force state=FETCH and illegal=0, and SHALL hold PCWrite, PCWriteCond, IRWrite and RegWrite at 0 and r_wbar at 1, regardless of state decode.
REQ-027 On the first rising clk edge after rst_n rises, the block SHALL perform FETCH outputs; reset asserted in any state, including HALT or mid-instruction, SHALL abort that instruction with no further writes.

Verification
REQ-028 The bench SHALL check: reset release, then opCode=100011 -> states 0,1,2,3,4,0, with RegWrite=1 and memToReg=1 only in state 4.
REQ-029 The bench SHALL check: opCode=101011 -> states 0,1,2,5,0, with r_wbar=0 and IorD=1 only in state 5, and RegWrite never 1.
REQ-030 The bench SHALL check: opCode=000000 -> 4-cycle sequence, aluop=10 in EXEC, RegDst=1 and RegWrite=1 in RWB; opCode=000100 -> PCWriteCond=1, PCSrc=01, aluop=01 for exactly 1 cycle.
REQ-031 The bench SHALL check: opCode=000010 -> PCWrite=1 and PCSrc=10 in state 9, then FETCH; opCode=111111 -> state 15 and illegal=1 held for 20 cycles.
REQ-032 The bench SHALL check: rst_n pulsed low mid-cycle during MEMRD -> state=0 immediately, all write strobes 0, and the next instruction is fetched normally.
REQ-033 The bench SHALL check: opCode=001000 -> states 0,1,10,11,0 with MC_ADDI_EN defined, and state 15 with illegal=1 without it.
